// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with optional 2-bit history counters; 0-cycle lookup, 1-cycle update.
// No backpressure: one update per cycle is always accepted; mispredict and redirect are combinational.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int MODE    = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_if_i,
    output logic             pred_taken_o,
    output logic [31:0]      pred_target_o,
    input  logic             upd_valid_i,
    input  logic [31:0]      upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [31:0]      upd_target_i,
    input  logic             upd_pred_taken_i,
    input  logic [31:0]      upd_pred_target_i,
    output logic             mispredict_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam bit BTB_ONLY = (MODE == 0);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       cnt_q    [ENTRIES];
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] idx_if, idx_u;
    logic [TAG_W-1:0] tag_if, tag_u;
    logic             hit_if, hit_u;
    logic             valid_d;
    logic [TAG_W-1:0] tag_d;
    logic [31:0]      target_d;
    logic [1:0]       cnt_d;
    logic             unused_pc_bits;

    assign idx_if = pc_if_i[IDX_W+1:2];
    assign tag_if = pc_if_i[31:IDX_W+2];
    assign idx_u  = upd_pc_i[IDX_W+1:2];
    assign tag_u  = upd_pc_i[31:IDX_W+2];
    assign unused_pc_bits = ^pc_if_i[1:0];

    assign hit_if        = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    assign pred_taken_o  = hit_if && (BTB_ONLY || cnt_q[idx_if][1]);
    assign pred_target_o = pred_taken_o ? target_q[idx_if] : 32'd0;

    assign mispredict_o  = upd_valid_i && ((upd_pred_taken_i != upd_taken_i) ||
                           (upd_taken_i && (upd_pred_target_i != upd_target_i)));
    assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 32'd4;

    assign hit_u = valid_q[idx_u] && (tag_q[idx_u] == tag_u);

    // Next contents of the single entry addressed by the resolving instruction.
    always_comb begin
        valid_d  = valid_q[idx_u];
        tag_d    = tag_q[idx_u];
        target_d = target_q[idx_u];
        cnt_d    = cnt_q[idx_u];
        if (upd_taken_i) begin
            target_d = upd_target_i;
            if (hit_u) begin
                if (cnt_d != 2'b11) cnt_d = cnt_d + 2'd1;
            end else begin
                valid_d = 1'b1;
                tag_d   = tag_u;
                cnt_d   = 2'b10;
            end
        end else if (hit_u) begin
            if (BTB_ONLY)
                valid_d = 1'b0;
            else if (cnt_d != 2'b00)
                cnt_d = cnt_d - 2'd1;
        end
    end

    assign branch_cnt_d  = branch_cnt_q + CNT_W'(1);
    assign mispred_cnt_d = mispred_cnt_q + CNT_W'(mispredict_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (upd_valid_i) begin
            valid_q[idx_u]  <= valid_d;
            tag_q[idx_u]    <= tag_d;
            target_q[idx_u] <= target_d;
            cnt_q[idx_u]    <= cnt_d;
            branch_cnt_q    <= branch_cnt_d;
            mispred_cnt_q   <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with per-entry 2-bit saturating history counters for the 5-stage RV32 pipeline. Provides a same-cycle taken/target prediction for the fetch PC in IF. Accepts resolution updates from EX and reports mispredictions with the correct redirect PC to the controller. Replaces the current fixed "predict not-taken, flush on taken branch in EX" policy and keeps performance counters.

## Interface
- `ENTRIES`, 64: table depth; power of two, 4..1024. `IDX_W = log2(ENTRIES)`.
- `MODE`, 1: 0 = BTB only (a hit predicts taken); 1 = BTB + 2-bit counter (a hit predicts taken iff `cnt[1]`).
- `CNT_W`, 32: width of the performance counters.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_if_i`  in  32  fetch PC to look up.
- `pred_taken_o`  out  1  prediction for `pc_if_i`; combinational from table state.
- `pred_target_o`  out  32  predicted target; 0 when `pred_taken_o`=0.
- `upd_valid_i`  in  1  EX resolves a conditional branch or JAL/JALR this cycle. At most one pulse per instruction; the controller suppresses it while EX is stalled.
- `upd_pc_i`  in  32  PC of the resolved instruction.
- `upd_taken_i`  in  1  actual outcome.
- `upd_target_i`  in  32  actual target; valid when taken.
- `upd_pred_taken_i`  in  1  prediction made at fetch, carried down the pipeline.
- `upd_pred_target_i`  in  32  predicted target made at fetch, carried down the pipeline.
- `mispredict_o`  out  1  combinational; flush IF/ID and redirect.
- `redirect_pc_o`  out  32  `upd_taken_i ? upd_target_i : upd_pc_i + 4`.
- `branch_cnt_o`  out  CNT_W  resolved control-flow instructions.
- `mispred_cnt_o`  out  CNT_W  mispredictions.

## Operation
- Entry fields: `valid`, `tag[31-IDX_W-2:0]`, `target[31:0]`, `cnt[1:0]`.
- Index is `pc[IDX_W+1:2]`. Tag is `pc[31:IDX_W+2]`. `pc[1:0]` is ignored.
- Lookup: `hit = valid[idx] && tag[idx]==pc_if_i tag`.
  - `pred_taken_o = hit && (MODE==0 || cnt[idx][1])`.
  - `pred_target_o = pred_taken_o ? target[idx] : 0`.
- Mispredict, when `upd_valid_i`=1:
  - `upd_pred_taken_i != upd_taken_i`, or
  - `upd_taken_i && upd_pred_target_i != upd_target_i`.
  - `mispredict_o` is 0 whenever `upd_valid_i`=0.
- Update, on the clock edge with `upd_valid_i`=1, using the update index and tag:
  - Hit and taken: `target <= upd_target_i`; `cnt` increments, saturating at 3.
  - Hit and not taken: `cnt` decrements, saturating at 0. In MODE 0 the entry is invalidated instead.
  - Miss and taken: allocate, overwriting any entry at that index. `valid<=1`, tag written, `target <= upd_target_i`, `cnt <= 2'b10`.
  - Miss and not taken: no table change.
- Counters: `branch_cnt_o` +1 per `upd_valid_i`; `mispred_cnt_o` +1 per `mispredict_o`. Both wrap modulo 2^CNT_W.
- Storage is flop-based, because lookup must be combinational; no RAM IP is used.

## Timing
- Lookup latency is 0 cycles: the prediction is valid in the same cycle as `pc_if_i`.
- Update latency is 1 cycle: the written entry is visible to lookups from the next cycle.
- Mispredict flag and redirect PC are combinational in the resolving cycle. The controller registers the PC set.
- Simultaneous lookup and update to the same index: the lookup returns pre-update contents (no bypass).
- Reset: all `valid`<=0, `cnt`<=2'b01, `target`/`tag`<=0, both perf counters <=0.
  - During and right after reset: `pred_taken_o`=0, `pred_target_o`=0.
  - `mispredict_o` and `redirect_pc_o` follow their inputs combinationally.
- `rst` asserted in the same cycle as `upd_valid_i`: reset wins, no update is recorded, counters go to 0.
- `redirect_pc_o` addition is 32-bit and wraps (`0xFFFFFFFC + 4 = 0`).

## Test plan
- Reset, then lookup of any PC -> `pred_taken_o`=0, `pred_target_o`=0, both counters 0.
- ENTRIES=64, MODE=1; update pc=0x100, taken, target=0x40 -> next cycle lookup 0x100 gives taken/0x40. Lookup 0x200 (same index, different tag) gives not taken.
- Four consecutive not-taken updates at 0x100 after allocation -> cnt 2→1→0→0. Prediction is not taken from the first update on, and the entry stays valid.
- Update with `upd_pred_taken_i`=1, `upd_pred_target_i`=0x40, taken, target=0x80 -> `mispredict_o`=1, `redirect_pc_o`=0x80, `mispred_cnt_o` +1.
- Not-taken mispredict at pc=0xFFFFFFFC -> `redirect_pc_o`=0x00000000.
- MODE=0: allocate 0x100, then a not-taken update -> entry invalidated, next lookup not taken. Same-cycle lookup/update of 0x100 returns the old entry.
